// File: rtl/vga_pkg.sv
// Constants shared by frame_streamer and vga_controller:
// raster extents, display window bounds and pixel format.
package vga_pkg;

    localparam int X_WINDOW_LOW  = 295;
    localparam int X_WINDOW_HIGH = 344;
    localparam int Y_WINDOW_LOW  = 215;
    localparam int Y_WINDOW_HIGH = 264;
    localparam int SCREEN_X      = 799;
    localparam int SCREEN_Y      = 524;
    localparam int FB_DEPTH      = 2500;
    localparam int PIX_W         = 6;
    localparam int XY_W          = 10;
    localparam int IDX_W         = 12;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [XY_W-1:0]  coord_t;

    // Inclusive range test used by the window decode.
    function automatic logic in_range(
        input coord_t v,
        input coord_t lo,
        input coord_t hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/fb_bram.sv
// Generic simple dual-port RAM: one write port, one registered read port.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), re_i/raddr_i -> rdata_o (1-cycle).
module fb_bram #(
    parameter int DEPTH = 2500,
    parameter int WIDTH = 6,
    parameter int AW    = 12
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Non-blocking read and write in one block: a same-address
    // collision returns the value held before the write.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < AW'(DEPTH))) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_streamer.sv
// Streams one full raster per request, framebuffer pixels inside the window,
// zero elsewhere. Ports: clk_20, reset, vga_ready_in, fb_we/fb_addr/fb_data
// (GPU write), vga_data_valid_in/vga_data_in (stream), frame_active,
// frame_done, overrun.
module frame_streamer #(
    parameter int FB_W     = vga_pkg::X_WINDOW_HIGH - vga_pkg::X_WINDOW_LOW + 1,
    parameter int FB_H     = vga_pkg::Y_WINDOW_HIGH - vga_pkg::Y_WINDOW_LOW + 1,
    parameter int FB_DEPTH = vga_pkg::FB_DEPTH,
    parameter int X_LAST   = vga_pkg::SCREEN_X,
    parameter int Y_LAST   = vga_pkg::SCREEN_Y,
    parameter int X_LOW    = vga_pkg::X_WINDOW_LOW,
    parameter int Y_LOW    = vga_pkg::Y_WINDOW_LOW
) (
    input  logic        clk_20,
    input  logic        reset,
    input  logic        vga_ready_in,
    input  logic        fb_we,
    input  logic [11:0] fb_addr,
    input  logic [5:0]  fb_data,
    output logic        vga_data_valid_in,
    output logic [5:0]  vga_data_in,
    output logic        frame_active,
    output logic        frame_done,
    output logic        overrun
);

    import vga_pkg::*;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    localparam coord_t XL = coord_t'(X_LOW);
    localparam coord_t XH = coord_t'(X_LOW + FB_W - 1);
    localparam coord_t YL = coord_t'(Y_LOW);
    localparam coord_t YH = coord_t'(Y_LOW + FB_H - 1);
    localparam coord_t XE = coord_t'(X_LAST);
    localparam coord_t YE = coord_t'(Y_LAST);

    // Stage 0 state
    logic             state_q, state_d;
    coord_t           x_q, x_d;
    coord_t           y_q, y_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;

    // Stage 1 state
    logic             valid_q;
    logic             inwin_q;
    logic             last_q;
    logic             done_q;

    logic             stream;
    logic             x_end;
    logic             y_end;
    logic             at_end;
    logic             inwin;
    pixel_t           rdata;

    assign stream = (state_q == ST_STREAM);
    assign x_end  = (x_q == XE);
    assign y_end  = (y_q == YE);
    assign at_end = stream && x_end && y_end;
    assign inwin  = stream && in_range(x_q, XL, XH)
                           && in_range(y_q, YL, YH);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        rd_idx_d  = rd_idx_q;
        pending_d = pending_q;
        // A request arriving with one already queued is dropped.
        overrun_d = overrun_q | (vga_ready_in & pending_q);
        unique case (state_q)
            ST_IDLE: begin
                if (vga_ready_in || pending_q) begin
                    state_d   = ST_STREAM;
                    x_d       = '0;
                    y_d       = '0;
                    rd_idx_d  = '0;
                    pending_d = 1'b0;
                end
            end
            ST_STREAM: begin
                // Never abort: downstream counters must stay aligned.
                if (vga_ready_in) begin
                    pending_d = 1'b1;
                end
                if (inwin) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
                if (x_end) begin
                    x_d = '0;
                    if (y_end) begin
                        y_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_20) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            rd_idx_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            inwin_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rd_idx_q  <= rd_idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= stream;
            inwin_q   <= inwin;
            // Done trails the last valid by one cycle.
            last_q    <= at_end;
            done_q    <= last_q;
        end
    end

    fb_bram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (PIX_W),
        .AW    (IDX_W)
    ) u_bram (
        .clk_i   (clk_20),
        .we_i    (fb_we),
        .waddr_i (fb_addr),
        .wdata_i (fb_data),
        .re_i    (inwin),
        .raddr_i (rd_idx_q),
        .rdata_o (rdata)
    );

    // The RAM output register doubles as the stage-1 pixel register.
    assign vga_data_valid_in = valid_q;
    assign vga_data_in       = inwin_q ? rdata : '0;
    assign frame_active      = valid_q;
    assign frame_done        = done_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer on a reduced 20x12 raster with an 8x6 window
// at (5,3), so each frame is 240 cycles.
module tb_frame_streamer;

    localparam int W   = 20;
    localparam int H   = 12;
    localparam int TOT = W * H;
    localparam int XL  = 5;
    localparam int YL  = 3;
    localparam int FW  = 8;
    localparam int FH  = 6;
    localparam int DEP = FW * FH;

    logic        clk = 0;
    logic        reset;
    logic        vga_ready_in;
    logic        fb_we;
    logic [11:0] fb_addr;
    logic [5:0]  fb_data;
    logic        vga_data_valid_in;
    logic [5:0]  vga_data_in;
    logic        frame_active;
    logic        frame_done;
    logic        overrun;

    frame_streamer #(
        .FB_W(FW), .FB_H(FH), .FB_DEPTH(DEP),
        .X_LAST(W - 1), .Y_LAST(H - 1),
        .X_LOW(XL), .Y_LOW(YL)
    ) dut (
        .clk_20            (clk),
        .reset             (reset),
        .vga_ready_in      (vga_ready_in),
        .fb_we             (fb_we),
        .fb_addr           (fb_addr),
        .fb_data           (fb_data),
        .vga_data_valid_in (vga_data_valid_in),
        .vga_data_in       (vga_data_in),
        .frame_active      (frame_active),
        .frame_done        (frame_done),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [5:0] ref_mem [DEP];
    logic [5:0] snap    [DEP];
    logic [5:0] frame_px[TOT];

    int f_start[$];
    int f_end[$];
    int f_len[$];
    int f_err[$];
    int f_done[$];
    int done_cnt = 0;
    int act_err  = 0;
    int pix      = 0;
    int cur_start = 0;
    int cur_err  = 0;
    logic prev_v = 0;

    typedef struct {
        int x;
        int y;
        int exp;
    } probe_t;
    probe_t tbl[10];

    always @(posedge clk) cyc++;

    // Expected raster pixel from its position and the memory image.
    function automatic int exp_pix(input int p);
        int x, y;
        x = p % W;
        y = p / W;
        if (x >= XL && x < XL + FW && y >= YL && y < YL + FH)
            return int'(snap[(y - YL) * FW + (x - XL)]);
        return 0;
    endfunction

    always @(negedge clk) begin
        if (vga_data_valid_in) begin
            if (!prev_v) begin
                snap      = ref_mem;
                pix       = 0;
                cur_start = cyc;
                cur_err   = 0;
            end
            if (pix < TOT) begin
                frame_px[pix] = vga_data_in;
                if (int'(vga_data_in) != exp_pix(pix)) cur_err++;
            end
            pix++;
        end else if (prev_v) begin
            f_start.push_back(cur_start);
            f_end.push_back(cyc - 1);
            f_len.push_back(pix);
            f_err.push_back(cur_err);
            f_done.push_back(int'(frame_done));
        end
        if (frame_done) done_cnt++;
        if (frame_active != vga_data_valid_in) act_err++;
        prev_v = vga_data_valid_in;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        fb_we   = 1;
        fb_addr = 12'(a);
        fb_data = 6'(d);
        tick();
        fb_we = 0;
        if (a < DEP) ref_mem[a] = 6'(d);
    endtask

    task automatic request(output int c0);
        vga_ready_in = 1;
        c0 = cyc;
        tick();
        vga_ready_in = 0;
    endtask

    task automatic pulse_at(input int c);
        while (cyc < c) tick();
        vga_ready_in = 1;
        tick();
        vga_ready_in = 0;
    endtask

    task automatic wait_frames(input string name, input int target);
        int k = 0;
        while (f_start.size() < target && k < 4 * TOT) begin
            tick();
            k++;
        end
        check(name, f_start.size(), target);
    endtask

    task automatic check_frame(input string name, input int i, input int st);
        if (i < f_start.size()) begin
            check({name, "_start"}, f_start[i], st);
            check({name, "_len"}, f_len[i], TOT);
            check({name, "_pix"}, f_err[i], 0);
            check({name, "_done"}, f_done[i], 1);
        end else begin
            check({name, "_missing"}, f_start.size(), i + 1);
        end
    endtask

    initial begin
        int c0, b, old;
        tbl[0] = '{XL, YL, 0};
        tbl[1] = '{XL + 1, YL, 1};
        tbl[2] = '{XL + FW - 1, YL + FH - 1, 47};
        tbl[3] = '{XL - 1, YL, 0};
        tbl[4] = '{XL + FW, YL + FH - 1, 0};
        tbl[5] = '{0, 0, 0};
        tbl[6] = '{W - 1, H - 1, 0};
        tbl[7] = '{XL, YL + 1, 8};
        tbl[8] = '{XL + FW - 1, YL, 7};
        tbl[9] = '{XL, YL + FH, 0};

        reset = 1;
        vga_ready_in = 0;
        fb_we = 0;
        fb_addr = 0;
        fb_data = 0;
        for (int i = 0; i < DEP; i++) ref_mem[i] = 0;
        repeat (3) tick();
        reset = 0;
        tick();
        check("rst_valid", int'(vga_data_valid_in), 0);
        check("rst_data", int'(vga_data_in), 0);
        check("rst_active", int'(frame_active), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);

        // Basic frame over a counting pattern.
        for (int i = 0; i < DEP; i++) wr(i, i % 64);
        request(c0);
        wait_frames("f1_wait", 1);
        check_frame("f1", 0, c0 + 2);
        repeat (5) tick();
        check("f1_done_cnt", done_cnt, 1);
        for (int i = 0; i < 10; i++)
            check($sformatf("probe%0d", i),
                  int'(frame_px[tbl[i].y * W + tbl[i].x]), tbl[i].exp);

        // Out-of-range writes leave memory untouched.
        wr(DEP, 6'h3F);
        wr(4095, 6'h3F);
        request(c0);
        wait_frames("oob_wait", 2);
        check_frame("oob", 1, c0 + 2);
        check("oob_last", int'(frame_px[(YL + FH - 1) * W + XL + FW - 1]), 47);

        // Random contents, random stray writes.
        for (int i = 0; i < DEP; i++) wr(i, int'($urandom_range(0, 63)));
        for (int i = 0; i < 8; i++)
            wr(int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)));
        repeat (3) tick();

        // Request mid-frame is queued, one idle cycle between frames.
        b = f_start.size();
        request(c0);
        pulse_at(c0 + 100);
        wait_frames("pend_wait", b + 2);
        check_frame("pend_a", b, c0 + 2);
        if (f_end.size() > b) check_frame("pend_b", b + 1, f_end[b] + 2);
        check("pend_overrun", int'(overrun), 0);
        repeat (TOT + 10) tick();
        check("pend_no_extra", f_start.size(), b + 2);

        // Request in the final streaming cycle still counts as pending.
        b = f_start.size();
        request(c0);
        pulse_at(c0 + TOT);
        wait_frames("edge_wait", b + 2);
        check("edge_end", (f_end.size() > b) ? f_end[b] : -1, c0 + TOT + 1);
        check_frame("edge_b", b + 1, c0 + TOT + 3);
        check("edge_overrun", int'(overrun), 0);
        repeat (TOT + 10) tick();

        // Two requests in one frame: overrun, a single extra frame.
        b = f_start.size();
        request(c0);
        pulse_at(c0 + 50);
        pulse_at(c0 + 80);
        check("ovr_flag", int'(overrun), 1);
        wait_frames("ovr_wait", b + 2);
        repeat (2 * TOT + 10) tick();
        check("ovr_frames", f_start.size(), b + 2);
        check("ovr_sticky", int'(overrun), 1);

        // Reset mid-frame with a queued request.
        b = f_start.size();
        request(c0);
        pulse_at(c0 + 30);
        while (cyc < c0 + 100) tick();
        reset = 1;
        tick();
        reset = 0;
        check("rst_mid_valid", int'(vga_data_valid_in), 0);
        check("rst_mid_overrun", int'(overrun), 0);
        repeat (2 * TOT) tick();
        check("rst_mid_no_pend", f_start.size(), b + 1);
        request(c0);
        wait_frames("rst_new_wait", b + 2);
        check_frame("rst_new", b + 1, c0 + 2);

        // GPU write to index 0 in the cycle the stream reads it.
        repeat (3) tick();
        b = f_start.size();
        old = int'(ref_mem[0]);
        request(c0);
        while (cyc < c0 + 1 + YL * W + XL) tick();
        fb_we = 1;
        fb_addr = 0;
        fb_data = 6'(old ^ 6'h3F);
        tick();
        fb_we = 0;
        ref_mem[0] = 6'(old ^ 6'h3F);
        wait_frames("col_wait", b + 1);
        check_frame("col", b, c0 + 2);
        check("col_old", int'(frame_px[YL * W + XL]), old);
        repeat (3) tick();
        request(c0);
        wait_frames("col2_wait", b + 2);
        check_frame("col2", b + 1, c0 + 2);
        check("col2_new", int'(frame_px[YL * W + XL]), old ^ 6'h3F);

        check("active_tracks_valid", act_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Source stage that feeds `vga_controller` in the `clk_20` domain. It holds the 50x50 GPU framebuffer and writes it into a local BRAM through a write port. On each `vga_ready_out` pulse it streams one full 800x525 raster in row-major order on `vga_data_valid_in`/`vga_data_in`. Inside the display window it emits framebuffer pixels; everywhere else it emits zero.

## Interface
Parameters:
- `FB_W`, default 50: window width in pixels.
- `FB_H`, default 50: window height in pixels.
- `FB_DEPTH`, default 2500: framebuffer entries (`FB_W*FB_H`).

Ports:
- `clk_20`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `vga_ready_in`  in  1  one-cycle frame request, driven by `vga_controller.vga_ready_out`.
- `fb_we`  in  1  GPU pixel write strobe.
- `fb_addr`  in  12  pixel index, `y*50+x`.
- `fb_data`  in  6  RGB222 pixel.
- `vga_data_valid_in`  out  1  raster stream valid.
- `vga_data_in`  out  6  raster pixel.
- `frame_active`  out  1  high while a frame is being streamed.
- `frame_done`  out  1  one-cycle pulse after the last pixel.
- `overrun`  out  1  sticky; set when a request arrives while one is already pending.

## Operation
- Memory: 2500x6 simple dual-port BRAM.
  - Write port: `fb_we` with `fb_addr < 2500` writes `fb_data`. Addresses of 2500 and above are ignored.
  - Read port: registered, 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old data. Tearing between GPU writes and the stream is accepted.
- FSM states: IDLE and STREAM.
  - IDLE, `vga_ready_in`=1 → STREAM. Clear counters `x`, `y`, `rd_idx`.
  - IDLE, `pending`=1 → STREAM. Clear `pending`.
  - STREAM: `x` runs 0..799. On `x`=799, `x` wraps to 0 and `y` increments; `y` runs 0..524.
  - STREAM: `rd_idx` increments on every in-window position.
  - STREAM, at (799,524) → IDLE.
- Window test: `295<=x<=344` and `215<=y<=264`. In-window positions read `mem[rd_idx]`. Out-of-window positions output 6'd0.
- Pending request:
  - `vga_ready_in` during STREAM sets `pending`. A frame is never aborted, because the downstream x/y counters must stay aligned.
  - `vga_ready_in` while `pending` is already 1 sets `overrun`. Only reset clears `overrun`.
- Frame gap: valid drops for at least 1 cycle between frames. This is needed so `vga_controller` resets its `write_index`.
- Widths: `x`, `y` are 10 bit; `rd_idx` is 12 bit. At frame end `rd_idx` must equal 2500.

## Timing
- Values after reset:
  - State IDLE; `pending`, `overrun` = 0.
  - Outputs: `vga_data_valid_in`=0, `vga_data_in`=0, `frame_active`=0, `frame_done`=0.
- Two-stage pipeline:
  - Stage 0: counters and window test.
  - Stage 1: BRAM read, output mux and output registers.
- Request at cycle t in IDLE → STREAM at t+1 → first valid pixel (0,0) at t+2.
- Valid is high for exactly 420000 consecutive cycles.
- `frame_done` pulses in the cycle after the last valid.
- With `pending` set, the next frame's first valid comes exactly 2 cycles after the previous last valid, so the gap is 1 idle cycle.
- `vga_ready_in` in the same cycle as the FSM leaving STREAM→IDLE counts as pending. The next frame starts normally, with no overrun.
- `reset` mid-frame:
  - Valid drops on the next cycle.
  - State → IDLE; `pending` is cleared.
  - BRAM contents are not cleared.
- A frame takes 21 ms at 20 MHz, longer than the 16.8 ms VGA frame. Steady state is therefore every frame being pending. This is intended; the ping-pong buffer downstream absorbs it.

## Structure
- Shared package `vga_pkg`: `X_WINDOW_LOW`=295, `X_WINDOW_HIGH`=344, `Y_WINDOW_LOW`=215, `Y_WINDOW_HIGH`=264, `SCREEN_X`=799, `SCREEN_Y`=524, `FB_DEPTH`=2500, pixel width 6. `vga_controller` uses the same constants.
- One sub-module: `fb_bram`, a generic simple dual-port BRAM with registered read. It holds the memory; the FSM, counters and output mux stay in `frame_streamer`.

## Test plan
- After reset, write `mem[i]=i%64` for all 2500 entries, then pulse `vga_ready_in`.
  - First valid 2 cycles later; exactly 420000 valids.
  - Pixel (295,215)=0, (296,215)=1, (344,264)=2499%64=3.
  - All out-of-window pixels are 0.
  - `frame_done` pulses once.
- Pulse `vga_ready_in` at pixel 1000 of a frame.
  - No abort; `pending` is set.
  - Exactly 1 idle cycle, then the second frame starts; `overrun`=0.
- Pulse `vga_ready_in` twice during one frame → `overrun`=1 and only one extra frame is streamed.
- `fb_we` with `fb_addr`=2500 and `fb_data`=6'h3F → no memory change. A following frame shows the previous contents.
- Assert `reset` mid-frame at pixel 5000.
  - Valid=0 on the next cycle; `pending` is cleared.
  - A new request streams from (0,0) with the BRAM contents preserved.
- GPU writes `mem[0]` in the same cycle the stream reads index 0 → old value is output. The next frame shows the new value.
